// File: rtl/tokenflow_pkg.sv
// Shared definitions for the tokenflow synchronous source: mode encodings,
// output FSM states and the alternating-pattern initial value.
package tokenflow_pkg;

  localparam logic [1:0] MODE_OBLONG = 2'd0;
  localparam logic [1:0] MODE_COUNT  = 2'd1;
  localparam logic [1:0] MODE_SQUARE = 2'd2;
  localparam logic [1:0] MODE_ALT    = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_HI,
    WAIT_LO
  } tx_state_e;

  // {w/2{2'b01}} zero-extended to 32 bits
  function automatic logic [31:0] alt_init(input int unsigned w);
    logic [31:0] v;
    v = '0;
    for (int unsigned i = 0; i < w / 2; i++) begin
      v = (v << 2) | 32'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/tokenflow_fifo.sv
// Show-ahead FIFO with extra-bit binary pointers and a synchronous flush.
module tokenflow_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A pop on a full FIFO frees the slot in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tokenflow_sync_src.sv
// Arithmetic token generator feeding a FIFO, drained over a 4-phase
// bundled-data req/ack channel with a synchronised asynchronous ack.
module tokenflow_sync_src
  import tokenflow_pkg::*;
#(
  parameter int unsigned W           = 16,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         restart,
  input  logic [1:0]   mode,
  input  logic         ack_in,
  output logic         req_out,
  output logic [W-1:0] data_out,
  output logic         wrap,
  output logic [15:0]  sent
);

  localparam logic [W-1:0] AltInit = W'(alt_init(W));

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_s;

  logic [1:0]   mode_q, mode_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] acc_q, acc_d;
  logic         wrap_q, wrap_d;
  logic [W-1:0] x_inc, term;
  logic [W:0]   sum;
  logic         gen_push;

  tx_state_e    state_q, state_d;
  logic         req_q, req_d;
  logic [W-1:0] data_q, data_d;
  logic [15:0]  sent_q, sent_d;
  logic         pop;

  logic [W-1:0] fifo_rdata;
  logic         fifo_full, fifo_empty;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], ack_in};
  assign ack_s  = sync_q[SYNC_STAGES-1];

  assign gen_push = en && !fifo_full && !restart;
  assign x_inc    = x_q + W'(1);

  always_comb begin
    unique case (mode_q)
      MODE_OBLONG: term = {x_inc[W-2:0], 1'b0};
      MODE_COUNT:  term = W'(1);
      MODE_SQUARE: term = {x_q[W-2:0], 1'b1};
      default:     term = '0;
    endcase
    sum = {1'b0, acc_q} + {1'b0, term};
  end

  always_comb begin
    mode_d = mode_q;
    x_d    = x_q;
    acc_d  = acc_q;
    wrap_d = wrap_q;
    if (restart) begin
      mode_d = mode;
      x_d    = '0;
      acc_d  = (mode == MODE_ALT) ? AltInit : '0;
      wrap_d = 1'b0;
    end else if (gen_push) begin
      if (mode_q == MODE_ALT) begin
        acc_d = ~acc_q;
      end else begin
        acc_d  = sum[W-1:0];
        wrap_d = wrap_q | sum[W];
      end
      if (mode_q == MODE_OBLONG || mode_q == MODE_SQUARE) x_d = x_inc;
    end
  end

  // Output FSM: data is registered on the pop so it leads req by a cycle.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    sent_d  = sent_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !ack_s) begin
          data_d  = fifo_rdata;
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        req_d   = 1'b1;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!ack_s) begin
          sent_d  = sent_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      mode_q  <= MODE_OBLONG;
      x_q     <= '0;
      acc_q   <= '0;
      wrap_q  <= 1'b0;
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      sent_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      wrap_q  <= wrap_d;
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      sent_q  <= sent_d;
    end
  end

  tokenflow_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (gen_push),
    .pop_i   (pop),
    .flush_i (restart),
    .wdata_i (acc_q),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign req_out  = req_q;
  assign data_out = data_q;
  assign wrap     = wrap_q;
  assign sent     = sent_q;

endmodule
